matrix_operand_loader: RTL and testbench

- Upstream feeder for the generic M×N × N×P matrix multiplier.
- Accepts one valid/ready byte stream per job: matrix A row-major, then matrix B row-major, with s_last on the final B element.
- Scatters elements into the multiplier's operand memories through its a_/b_ write ports.
- Runs the multiplier's start/done handshake, then re-arms for the next frame.

---
 rtl/matrix_operand_loader.sv | 142 ++++++++++++++
 tb/tb_matrix_operand_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_operand_loader.sv
// Stream-to-operand-memory loader for the M x N x P matrix multiplier.
// Takes A then B row-major from one valid/ready stream, writes the operand memories, then runs start/done.
module matrix_operand_loader #(
    parameter int M          = 3,
    parameter int N          = 3,
    parameter int P          = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       s_data,
    input  logic                        s_valid,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic [DATA_WIDTH-1:0]       a_in,
    output logic [$clog2(M*N)-1:0]      a_addr,
    output logic                        a_wen,
    output logic [DATA_WIDTH-1:0]       b_in,
    output logic [$clog2(N*P)-1:0]      b_addr,
    output logic                        b_wen,
    output logic                        start,
    input  logic                        done,
    output logic                        frame_err,
    output logic                        busy,
    output logic [15:0]                 frame_count
);

    // state    | meaning
    // LOAD_A   | accepting A elements, counter = next A index
    // LOAD_B   | accepting B elements, counter = next B index
    // LAUNCH   | one cycle so the final B write lands before start
    // RUN      | start held high, waiting for done
    // RELEASE  | start dropped, waiting for done to fall

    localparam int NA   = M * N;
    localparam int NB   = N * P;
    localparam int AW   = $clog2(NA);
    localparam int BW   = $clog2(NB);
    localparam int KMAX = (NA > NB) ? NA : NB;
    localparam int KW   = $clog2(KMAX);

    typedef enum logic [2:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_LAUNCH,
        S_RUN,
        S_RELEASE
    } state_t;

    state_t        state;
    logic [KW-1:0] cnt;
    logic          last_a;
    logic          last_b;

    assign last_a  = (cnt == KW'(NA - 1));
    assign last_b  = (cnt == KW'(NB - 1));
    // Gated by rst so the stream sees not-ready for the whole reset window.
    assign s_ready = !rst && ((state == S_LOAD_A) || (state == S_LOAD_B));
    assign busy    = (state != S_LOAD_A) || (cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_LOAD_A;
            cnt         <= '0;
            a_in        <= '0;
            a_addr      <= '0;
            a_wen       <= 1'b0;
            b_in        <= '0;
            b_addr      <= '0;
            b_wen       <= 1'b0;
            start       <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            a_wen     <= 1'b0;
            b_wen     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_LOAD_A: begin
                    if (s_valid) begin
                        if (s_last) begin
                            frame_err <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            a_wen  <= 1'b1;
                            a_addr <= AW'(cnt);
                            a_in   <= s_data;
                            if (last_a) begin
                                cnt   <= '0;
                                state <= S_LOAD_B;
                            end else begin
                                cnt <= cnt + KW'(1);
                            end
                        end
                    end
                end
                S_LOAD_B: begin
                    if (s_valid) begin
                        // s_last must coincide exactly with the final B element
                        if (s_last != last_b) begin
                            frame_err <= 1'b1;
                            cnt       <= '0;
                            state     <= S_LOAD_A;
                        end else begin
                            b_wen  <= 1'b1;
                            b_addr <= BW'(cnt);
                            b_in   <= s_data;
                            if (last_b) begin
                                cnt   <= '0;
                                state <= S_LAUNCH;
                            end else begin
                                cnt <= cnt + KW'(1);
                            end
                        end
                    end
                end
                S_LAUNCH: begin
                    start <= 1'b1;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (done) begin
                        start <= 1'b0;
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!done) begin
                        frame_count <= frame_count + 16'd1;
                        cnt         <= '0;
                        state       <= S_LOAD_A;
                    end
                end
                default: begin
                    state <= S_LOAD_A;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Bench for matrix_operand_loader: directed and random frames, operand memories captured and compared to the stream.
module tb_matrix_operand_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [7:0]  a_in;
    logic [3:0]  a_addr;
    logic        a_wen;
    logic [7:0]  b_in;
    logic [3:0]  b_addr;
    logic        b_wen;
    logic        start;
    logic        done;
    logic        frame_err;
    logic        busy;
    logic [15:0] frame_count;

    matrix_operand_loader #(.M(3), .N(3), .P(3), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .a_in(a_in), .a_addr(a_addr), .a_wen(a_wen),
        .b_in(b_in), .b_addr(b_addr), .b_wen(b_wen), .start(start), .done(done),
        .frame_err(frame_err), .busy(busy), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural multiplier memories, stamped with the frame that wrote them
    logic [7:0] mem_a [0:8];
    logic [7:0] mem_b [0:8];
    int         stamp_a [0:8];
    int         stamp_b [0:8];
    int         a_wr = 0, b_wr = 0, err_pulses = 0, bad_addr = 0;
    int         frame_id = 0;

    always @(negedge clk) begin
        if (a_wen) begin
            if (a_addr < 4'd9) begin
                mem_a[a_addr]   <= a_in;
                stamp_a[a_addr] <= frame_id;
            end else begin
                bad_addr <= bad_addr + 1;
            end
            a_wr <= a_wr + 1;
        end
        if (b_wen) begin
            if (b_addr < 4'd9) begin
                mem_b[b_addr]   <= b_in;
                stamp_b[b_addr] <= frame_id;
            end else begin
                bad_addr <= bad_addr + 1;
            end
            b_wr <= b_wr + 1;
        end
        if (frame_err) err_pulses <= err_pulses + 1;
    end

    logic [7:0] fd [0:17];
    int         last_pos;
    int         exp_fc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int sel);
        for (int i = 0; i < 9; i++) begin
            case (sel)
                0: begin fd[i] = 8'(i + 1); fd[9+i] = (i % 4 == 0) ? 8'd1 : 8'd0; end
                1: begin fd[i] = (i % 4 == 0) ? 8'd2 : 8'd0; fd[9+i] = 8'd3; end
                2: begin fd[i] = (i % 4 == 0) ? 8'hFF : 8'd0; fd[9+i] = 8'(i + 1); end
                default: begin fd[i] = 8'($urandom); fd[9+i] = 8'($urandom); end
            endcase
        end
    endtask

    // gap: 0 continuous, 1 every other cycle, 2 random
    task automatic send_beats(input int nbeats, input int gap);
        int  beat = 0;
        int  cyc  = 0;
        logic acc;
        while (beat < nbeats && cyc < 400) begin
            @(negedge clk);
            case (gap)
                0:       s_valid = 1'b1;
                1:       s_valid = (cyc % 2 == 0);
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_data = fd[beat];
            s_last = (beat == last_pos);
            #1;
            acc = s_valid && s_ready;
            @(posedge clk);
            if (acc) beat++;
            cyc++;
        end
        chk("beats_accepted", beat, nbeats);
    endtask

    task automatic run_clean(input int gap, input int done_delay);
        int a0, b0, k;
        frame_id++;
        last_pos = 17;
        a0 = a_wr;
        b0 = b_wr;
        send_beats(18, gap);
        @(negedge clk);
        s_valid = 1'b1; s_data = 8'hEE; s_last = 1'b0;
        chk("last_b_wen", b_wen, 1);
        chk("last_b_addr", b_addr, 8);
        chk("last_b_data", b_in, fd[17]);
        chk("start_early", start, 0);
        @(negedge clk);
        chk("start_rise", start, 1);
        chk("ready_launch", s_ready, 0);
        chk("busy_run", busy, 1);
        repeat (done_delay) @(negedge clk);
        chk("start_held", start, 1);
        done = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (start && k < 10);
        chk("start_drop_lat", k, 1);
        repeat (2) @(negedge clk);
        chk("ready_release", s_ready, 0);
        chk("start_release", start, 0);
        done    = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        exp_fc++;
        chk("ready_rearm", s_ready, 1);
        chk("frame_count", frame_count, exp_fc);
        chk("busy_idle", busy, 0);
        chk("a_writes", a_wr - a0, 9);
        chk("b_writes", b_wr - b0, 9);
        for (int i = 0; i < 9; i++) begin
            chk("a_stamp", stamp_a[i], frame_id);
            chk("a_mem", mem_a[i], fd[i]);
            chk("b_stamp", stamp_b[i], frame_id);
            chk("b_mem", mem_b[i], fd[9+i]);
        end
    endtask

    // kind 0: s_last on beat errpos (< 17); kind 1: final beat without s_last
    task automatic run_err(input int errpos, input int kind, input int gap);
        int a0, b0, e0, na, nb;
        frame_id++;
        last_pos = (kind == 1) ? -1 : errpos;
        a0 = a_wr; b0 = b_wr; e0 = err_pulses;
        send_beats(errpos + 1, gap);
        @(negedge clk);
        s_valid = 1'b0;
        chk("err_pulse", frame_err, 1);
        chk("err_busy", busy, 0);
        chk("err_ready", s_ready, 1);
        @(negedge clk);
        chk("err_one_cycle", frame_err, 0);
        repeat (3) @(negedge clk);
        chk("err_no_start", start, 0);
        na = (errpos < 9) ? errpos : 9;
        nb = (errpos > 9) ? errpos - 9 : 0;
        chk("err_a_writes", a_wr - a0, na);
        chk("err_b_writes", b_wr - b0, nb);
        chk("err_count", err_pulses - e0, 1);
        chk("err_frame_count", frame_count, exp_fc);
        for (int i = 0; i < na; i++) chk("err_a_mem", mem_a[i], fd[i]);
        for (int i = 0; i < nb; i++) chk("err_b_mem", mem_b[i], fd[9+i]);
    endtask

    initial begin
        rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; done = 1'b0;
        for (int i = 0; i < 9; i++) begin stamp_a[i] = 0; stamp_b[i] = 0; end
        #12;
        chk("rst_ready", s_ready, 0);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_a_wen", a_wen, 0);
        chk("rst_fc", frame_count, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", s_ready, 1);

        fill(0); run_clean(0, 2);
        fill(0); run_clean(1, 0);
        fill(0); run_err(4, 0, 0);
        fill(0); run_clean(0, 1);
        fill(3); run_err(17, 1, 0);
        fill(3); run_err(8, 0, 1);
        fill(3); run_err(12, 0, 2);
        fill(1); run_clean(0, 3);
        fill(2); run_clean(0, 0);

        // Reset while RUN holds start
        fill(3);
        frame_id++;
        last_pos = 17;
        send_beats(18, 0);
        @(negedge clk); s_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_start", start, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_start", start, 0);
        chk("async_ready", s_ready, 0);
        chk("async_busy", busy, 0);
        chk("async_fc", frame_count, 0);
        exp_fc = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rearm_ready", s_ready, 1);
        fill(0); run_clean(0, 1);

        for (int r = 0; r < 10; r++) begin
            fill(3);
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0) run_err($urandom_range(0, 16), 0, 2);
                else                           run_err(17, 1, 2);
            end else begin
                run_clean($urandom_range(0, 2), $urandom_range(0, 4));
            end
        end

        chk("bad_addr", bad_addr, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
